touch_adc_spi_responder: RTL and testbench
==========================================

# touch_adc_spi_responder

Synthesizable SPI responder that emulates the ADS7843-style 4-wire touch-panel ADC on the far end of the SOPC touch-panel SPI master, busy input and pen-IRQ input. It decodes 8-bit control bytes from MOSI and returns 12-bit (optionally 8-bit) channel samples on MISO. It also drives BUSY and PENIRQ_n exactly as the driver expects. It lets the touch driver and SOPC system be exercised on hardware and in simulation without the LT24 touch controller fitted. Position and pressure values come from parallel input ports.

## Interface
- SYNC_STAGES, 2: synchronizer flops on sclk/mosi/ss_n (min 2)
- DATA_W, 12: full-resolution sample width

- clk  in  1  system clock; must be ≥ 8× SCLK frequency
- reset_n  in  1  synchronous, active-low reset
- spi_sclk  in  1  SPI clock from master, async to clk, idle low (mode 0)
- spi_mosi  in  1  master data, sampled on SCLK rising edge
- spi_ss_n  in  1  chip select, active low
- spi_miso  out  1  responder data, updated on SCLK falling edge
- busy  out  1  conversion-busy indication to master
- pen_irq_n  out  1  pen interrupt, active low
- touch  in  1  panel currently touched
- x_pos, y_pos, z1, z2  in  DATA_W each  channel values to return
- cmd_valid  out  1  one-clk pulse when a full control byte is decoded
- cmd_byte  out  8  last decoded control byte

## Operation
- sclk/mosi/ss_n pass through SYNC_STAGES flops. Rising (R) and falling (F) SCLK events are detected only while synced ss_n is low.
- Control byte layout, MSB first: S, A2..A0, MODE, SER/DFR, PD1, PD0. Leading zeros before S are ignored.
- Channel map: A=101 → x_pos; 001 → y_pos; 011 → z1; 100 → z2; all other codes → 0.
- States:
  - HUNT: miso=0, busy=0. R with mosi=1 → CMD. That bit is S (bit 7), and the bit counter is cleared.
  - CMD: each R shifts mosi into cmd[6:0]. On the 7th such R: latch the selected channel into the shift register, update cmd_byte, pulse cmd_valid, update pen_irq_en=~PD0, then → CONV.
  - CONV: 1st F → busy=1. 2nd F → busy=0, miso=MSB, then → DATA with N-1 bits remaining. N=DATA_W, or 8 in 8-bit mode.
  - DATA: each F presents the next bit. The F after the LSB sets miso=0 and returns to HUNT.
- 8-bit mode returns sample[DATA_W-1:DATA_W-8] (truncated, not rounded).
- pen_irq_n = ~(touch & pen_irq_en) in HUNT, and is forced to 1 in CMD/CONV/DATA. pen_irq_en resets to 1.
- ss_n rising (synced) in any state: → HUNT, miso=0, busy=0, counters cleared. cmd_byte and pen_irq_en are retained.
- The channel value is captured once, at the command-completing R. Input changes after that do not affect the word in flight.

## Timing
- Reset values: spi_miso=0, busy=0, pen_irq_n=1 (touch low), cmd_valid=0, cmd_byte=8'h00, state HUNT.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles from any input transition.
- All outputs are registered.
- Counting SCLK clocks from 1 after ss_n falls (a 24-clock frame), with no leading zeros:
  - command is clocked on R1..R8
  - busy is high from F8 to F9
  - data bits are driven on F9..F20 and the master samples them on R10..R21
  - miso returns to 0 at F21
- Simultaneous R and ss_n deassert in the same clk: ss_n wins.
- Reset is synchronous and wins over everything.
- Back-to-back frames without deasserting ss_n are legal, because HUNT resumes start-bit search immediately.

## Configuration
- TOUCH_RESP_8BIT_MODE_EN defined: the MODE bit is honoured. MODE=1 returns 8 bits and the frame ends at F17.
- Undefined: MODE is ignored and all conversions return DATA_W bits. cmd_byte still reports the MODE bit as received.

## Structure
- touch_resp_pkg holds:
  - state enum (HUNT, CMD, CONV, DATA)
  - channel code constants (CH_X=3'b101, CH_Y=3'b001, CH_Z1=3'b011, CH_Z2=3'b100)
  - control-byte bit-position localparams
- Sub-module touch_resp_sync: the SYNC_STAGES synchronizer plus R/F edge detect, with ss_n gating.

## Test plan
- cmd 8'hD0, x_pos=12'hABC, 24-clock frame → MISO 1010_1011_1100 sampled on R10..R21; busy high only between F8 and F9; cmd_valid pulses once; cmd_byte=8'hD0.
- Three leading zeros, then cmd 8'h90, y_pos=12'h5A5 → start detected on R4, data 0101_1010_0101, timing shifted by 3 clocks.
- With macro: cmd 8'hD8, x_pos=12'hABC → 8 bits 1010_1011, miso=0 from F17. Without macro: the same frame returns 12 bits.
- ss_n raised after F12 mid-DATA → miso=0 and busy=0 within SYNC_STAGES+1 clk. The next frame with cmd 8'hB0, z1=12'h123 returns 12'h123 correctly.
- touch=1 with PD0=0 → pen_irq_n=0 in HUNT and forced 1 during a frame. After cmd 8'hD1 (PD0=1), touch=1 → pen_irq_n stays 1.
- reset_n low mid-CONV → next clk: busy=0, miso=0, pen_irq_n=1, cmd_byte=0, HUNT.

Source files
------------

// File: rtl/touch_resp_pkg.sv
// touch_resp_pkg: shared FSM states, channel codes and control-byte bit positions for the touch ADC responder
package touch_resp_pkg;
  typedef enum logic [1:0] {HUNT, CMD, CONV, DATA} state_e;
  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;
  localparam logic [2:0] CH_Z2 = 3'b100;
  localparam int CB_S    = 7;
  localparam int CB_A_HI = 6;
  localparam int CB_A_LO = 4;
  localparam int CB_MODE = 3;
  localparam int CB_SER  = 2;
  localparam int CB_PD1  = 1;
  localparam int CB_PD0  = 0;
endpackage

// File: rtl/touch_adc_spi_responder_if.sv
// touch_adc_spi_responder_if: SPI pins plus BUSY and PENIRQ_n between touch-panel master and responder
interface touch_adc_spi_responder_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_ss_n;
  logic spi_miso;
  logic busy;
  logic pen_irq_n;
  modport master (output spi_sclk, spi_mosi, spi_ss_n, input spi_miso, busy, pen_irq_n);
  modport slave  (input spi_sclk, spi_mosi, spi_ss_n, output spi_miso, busy, pen_irq_n);
endinterface

// File: rtl/touch_resp_sync.sv
// touch_resp_sync: synchronizes sclk/mosi/ss_n into clk and flags SCLK edges while selected plus ss_n release
module touch_resp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic ss_n_i,
  output logic rise_o,
  output logic fall_o,
  output logic mosi_o,
  output logic ss_rise_o
);
  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
  logic sclk_prev_q, ss_prev_q, sclk_s, ss_s;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      ss_q        <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      ss_q        <= {ss_q[SYNC_STAGES-2:0], ss_n_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign mosi_o    = mosi_q[SYNC_STAGES-1];
  assign rise_o    = sclk_s & ~sclk_prev_q & ~ss_s;
  assign fall_o    = ~sclk_s & sclk_prev_q & ~ss_s;
  assign ss_rise_o = ss_s & ~ss_prev_q;
endmodule

// File: rtl/touch_adc_spi_responder.sv
// touch_adc_spi_responder: ADS7843-style touch ADC emulator answering control bytes with channel samples over SPI.
// Define TOUCH_RESP_8BIT_MODE_EN to honour the MODE bit (8-bit conversions).
module touch_adc_spi_responder
  import touch_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  touch_adc_spi_responder_if.slave spi,
  input  logic                    touch,
  input  logic [DATA_W-1:0]       x_pos,
  input  logic [DATA_W-1:0]       y_pos,
  input  logic [DATA_W-1:0]       z1,
  input  logic [DATA_W-1:0]       z2,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic rise, fall, mosi_s, ss_rise, cmd_done;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, first_rem;
  logic [5:0] cmd_q, cmd_d;
  logic [7:0] full, cmd_byte_q, cmd_byte_d;
  logic [DATA_W-1:0] shift_q, shift_d, sample;
  logic cmd_valid_q, cmd_valid_d, busy_q, busy_d, miso_q, miso_d;
  logic pen_en_q, pen_en_d, pen_irq_n_q, pen_irq_n_d;
  touch_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sclk_i   (spi.spi_sclk),
    .mosi_i   (spi.spi_mosi),
    .ss_n_i   (spi.spi_ss_n),
    .rise_o   (rise),
    .fall_o   (fall),
    .mosi_o   (mosi_s),
    .ss_rise_o(ss_rise)
  );
  // S is implicit: the byte is only assembled once the start bit has been seen
  assign full     = {1'b1, cmd_q, mosi_s};
  assign cmd_done = (state_q == CMD) && rise && (cnt_q == CW'(6));
  assign sample   = (full[CB_A_HI:CB_A_LO] == CH_X)  ? x_pos :
                    (full[CB_A_HI:CB_A_LO] == CH_Y)  ? y_pos :
                    (full[CB_A_HI:CB_A_LO] == CH_Z1) ? z1 :
                    (full[CB_A_HI:CB_A_LO] == CH_Z2) ? z2 : '0;
`ifdef TOUCH_RESP_8BIT_MODE_EN
  logic mode8_q;
  always_ff @(posedge clk) begin
    if (!reset_n) mode8_q <= 1'b0;
    else if (cmd_done) mode8_q <= full[CB_MODE];
  end
  assign first_rem = mode8_q ? CW'(7) : CW'(DATA_W - 1);
`else
  assign first_rem = CW'(DATA_W - 1);
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    miso_d      = miso_q;
    pen_en_d    = pen_en_q;
    if (ss_rise) begin
      state_d = HUNT;
      cnt_d   = '0;
      busy_d  = 1'b0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          busy_d = 1'b0;
          miso_d = 1'b0;
          if (rise && mosi_s) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: if (rise) begin
          cmd_d = {cmd_q[4:0], mosi_s};
          cnt_d = cnt_q + CW'(1);
          if (cmd_done) begin
            shift_d     = sample;
            cmd_byte_d  = full;
            cmd_valid_d = 1'b1;
            pen_en_d    = ~full[CB_PD0];
            cnt_d       = '0;
            state_d     = CONV;
          end
        end
        CONV: if (fall) begin
          if (cnt_q == '0) begin
            busy_d = 1'b1;
            cnt_d  = CW'(1);
          end else begin
            busy_d  = 1'b0;
            miso_d  = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = first_rem;
            state_d = DATA;
          end
        end
        DATA: if (fall) begin
          miso_d  = (cnt_q == '0) ? 1'b0 : shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
          state_d = (cnt_q == '0) ? HUNT : DATA;
        end
        default: state_d = HUNT;
      endcase
    end
    pen_irq_n_d = (state_d == HUNT) ? ~(touch & pen_en_d) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      pen_en_q    <= 1'b1;
      pen_irq_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      pen_en_q    <= pen_en_d;
      pen_irq_n_q <= pen_irq_n_d;
    end
  end
  assign spi.spi_miso  = miso_q;
  assign spi.busy      = busy_q;
  assign spi.pen_irq_n = pen_irq_n_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_byte      = cmd_byte_q;
endmodule

// File: tb/tb_touch_adc_spi_responder.sv
// tb_touch_adc_spi_responder: drives SPI frames and checks MISO/BUSY/PENIRQ_n/cmd outputs against a frame-level model
module tb_touch_adc_spi_responder;
  localparam int DW = 12, SYNC = 2, HALF = 5;
  logic clk = 1'b0, reset_n = 1'b0, touch = 1'b0, cmd_valid;
  logic [DW-1:0] x_pos = '0, y_pos = '0, z1 = '0, z2 = '0;
  logic [7:0] cmd_byte;
  int checks = 0, failures = 0, vtot = 0;
  logic en_m = 1'b1;
  logic [7:0] cb_m = 8'h00;
  touch_adc_spi_responder_if spi_if ();
  touch_adc_spi_responder #(.SYNC_STAGES(SYNC), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi      (spi_if),
    .touch    (touch),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .z1       (z1),
    .z2       (z2),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (cmd_valid === 1'b1) vtot++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] chan(input logic [2:0] a);
    return a == 3'b101 ? x_pos : a == 3'b001 ? y_pos : a == 3'b011 ? z1 : a == 3'b100 ? z2 : '0;
  endfunction
  function automatic int nbits(input logic [7:0] c);
`ifdef TOUCH_RESP_8BIT_MODE_EN
    return c[3] ? 8 : DW;
`else
    return (c == 8'h00) ? DW : DW;
`endif
  endfunction
  // One frame: lead zeros, command byte, then clocks to lead+24; optional abort after F abort_k or reset before R rst_k
  task automatic frame(input int lead, input logic [7:0] cmd, input int abort_k, input int rst_k);
    int s, n, v0;
    logic [DW-1:0] smp;
    logic e_miso, e_pen;
    s = lead + 1;
    n = nbits(cmd);
    smp = chan(cmd[6:4]);
    v0 = vtot;
    @(negedge clk);
    spi_if.spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("pen_pre", 32'(spi_if.pen_irq_n), 32'(1'(~(touch & en_m))));
    for (int k = 1; k <= lead + 24; k++) begin
      spi_if.spi_mosi = (k >= s && k <= s + 7) ? cmd[7 - (k - s)] :
                        (k > s + 7 && k <= s + 8 + n) ? 1'($urandom) : 1'b0;
      if (k == s + 9) begin
        x_pos = DW'($urandom);
        y_pos = DW'($urandom);
        z1 = DW'($urandom);
        z2 = DW'($urandom);
      end
      repeat (HALF) @(negedge clk);
      e_miso = (k >= s + 9 && k < s + 9 + n) ? smp[DW - 1 - (k - s - 9)] : 1'b0;
      e_pen = (k > s && k <= s + 8 + n) ? 1'b1 : ~(touch & (k <= s ? en_m : ~cmd[0]));
      chk("miso", 32'(spi_if.spi_miso), 32'(e_miso));
      chk("busy", 32'(spi_if.busy), 32'(k == s + 8));
      chk("pen_irq_n", 32'(spi_if.pen_irq_n), 32'(e_pen));
      if (k == rst_k) begin
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(spi_if.busy), 32'd0);
        chk("rst_miso", 32'(spi_if.spi_miso), 32'd0);
        chk("rst_pen", 32'(spi_if.pen_irq_n), 32'd1);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        spi_if.spi_ss_n = 1'b1;
        spi_if.spi_mosi = 1'b0;
        en_m = 1'b1;
        cb_m = 8'h00;
        repeat (HALF) @(negedge clk);
        return;
      end
      spi_if.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.spi_sclk = 1'b0;
      if (k == abort_k) begin
        spi_if.spi_ss_n = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        chk("abort_miso", 32'(spi_if.spi_miso), 32'd0);
        chk("abort_busy", 32'(spi_if.busy), 32'd0);
        break;
      end
    end
    en_m = ~cmd[0];
    cb_m = cmd;
    spi_if.spi_ss_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("cmd_byte", 32'(cmd_byte), 32'(cb_m));
    chk("cmd_valid_pulses", 32'(vtot - v0), 32'd1);
    chk("end_miso", 32'(spi_if.spi_miso), 32'd0);
    chk("end_busy", 32'(spi_if.busy), 32'd0);
    chk("end_pen", 32'(spi_if.pen_irq_n), 32'(1'(~(touch & en_m))));
  endtask
  initial begin
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_mosi = 1'b0;
    spi_if.spi_ss_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_miso", 32'(spi_if.spi_miso), 32'd0);
    chk("reset_busy", 32'(spi_if.busy), 32'd0);
    chk("reset_pen", 32'(spi_if.pen_irq_n), 32'd1);
    chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset_cmd_byte", 32'(cmd_byte), 32'd0);
    x_pos = 12'hABC;
    frame(0, 8'hD0, 0, 0);
    y_pos = 12'h5A5;
    frame(3, 8'h90, 0, 0);
    x_pos = 12'hABC;
    frame(0, 8'hD8, 0, 0);
    x_pos = 12'hFFF;
    frame(0, 8'hD0, 12, 0);
    z1 = 12'h123;
    frame(0, 8'hB0, 0, 0);
    z2 = 12'h9C3;
    frame(2, 8'hC0, 0, 0);
    touch = 1'b1;
    frame(0, 8'hD0, 0, 0);
    frame(0, 8'hD1, 0, 0);
    frame(1, 8'hD0, 0, 0);
    touch = 1'b0;
    x_pos = 12'h7E1;
    frame(0, 8'hD0, 0, 9);
    frame(2, 8'hDC, 0, 0);
    repeat (20) begin
      touch = 1'($urandom);
      x_pos = DW'($urandom);
      y_pos = DW'($urandom);
      z1 = DW'($urandom);
      z2 = DW'($urandom);
      frame(int'($urandom_range(0, 3)), {1'b1, 7'($urandom)}, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
